uart_tx_serializer: RTL and testbench

Parametrised UART transmit serializer, next generation of the team's fixed 32-bit TX shift register. Adds configurable data width, parity mode, stop-bit count, an internal baud divider, a one-entry holding buffer, and a valid/ready handshake, so the APB UART can write back-to-back words without gaps. Sits between the APB UART TX data register and the serial pad.

---
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmit serializer with a one-word holding buffer, internal baud divider, optional parity and 1/2 stop bits.
// Latency: a word accepted at edge E0 enters START at E1; frames run back-to-back when the buffer is full at the last stop cycle.
// Backpressure: tx_ready is low while the holding buffer is occupied; it frees on the edge that starts the buffered word's frame.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    // Reject parameter combinations the datapath cannot represent.
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
        $error("uart_tx_serializer: DATA_WIDTH must be in 1..64");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] LAST_BAUD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PARITY = (PARITY_MODE != 0);
    localparam logic              PAR_INV    = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    buf_full;
    logic [DATA_WIDTH-1:0]   buf_dat;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    parity_bit;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    bit_end;
    logic                    frame_end;
    logic                    load;

    assign bit_end   = (baud_cnt == LAST_BAUD);
    assign frame_end = (state == S_STOP) && bit_end && (bit_cnt == LAST_STOP);
    // A frame starts whenever the FSM enters START from IDLE or straight from STOP.
    assign load      = (state_nxt == S_START) && (state != S_START);
    assign tx_ready  = !buf_full;
    assign tx_busy   = (state != S_IDLE);

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: walk START, DATA, optional PARITY, STOP; chain frames when a word is waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (buf_full) state_nxt = S_START;
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == LAST_DATA) state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (frame_end) state_nxt = buf_full ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line driver: idle and stop are marks, start is a space, data goes out LSB first.
    always_comb begin
        tx_serial = 1'b1;
        case (state)
            S_START:  tx_serial = 1'b0;
            S_DATA:   tx_serial = shift_reg[0];
            S_PARITY: tx_serial = parity_bit;
            default:  tx_serial = 1'b1;
        endcase
    end

    // Holding buffer: filled on handshake, emptied when its word moves into the shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_dat  <= '0;
        end else if (tx_valid && tx_ready) begin
            buf_full <= 1'b1;
            buf_dat  <= tx_data;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    // Baud and bit counters, shifter, parity capture and the end-of-frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= frame_end;

            if (state == S_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            // bit_cnt indexes data bits in DATA and stop bits in STOP; restart on every state change.
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (load) begin
                shift_reg  <= buf_dat;
                parity_bit <= (^buf_dat) ^ PAR_INV;
            end else if (state == S_DATA && bit_end) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations side by side, each checked every cycle
// against a frame-queue model, plus directed frames with hand-computed bit patterns.
module tb_uart_tx_serializer;

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  vld_v;
    logic [63:0] dat_a [3];
    logic [2:0]  rdy_v;
    logic [2:0]  ser_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  hs_v;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Instance 0: 8 bits, 4 clk/bit, even parity, 1 stop.
    // Instance 1: 32 bits, 16 clk/bit, odd parity, 1 stop.
    // Instance 2: 8 bits, 4 clk/bit, no parity, 2 stops.
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DW  = (g == 1) ? 32 : 8;
        localparam int CPB = (g == 1) ? 16 : 4;
        localparam int PM  = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
        localparam int SB  = (g == 2) ? 2 : 1;

        uart_tx_serializer #(
            .DATA_WIDTH  (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_MODE (PM),
            .STOP_BITS   (SB)
        ) dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .tx_data  (dat_a[g][DW-1:0]),
            .tx_valid (vld_v[g]),
            .tx_ready (rdy_v[g]),
            .tx_serial(ser_v[g]),
            .tx_busy  (busy_v[g]),
            .tx_done  (done_v[g])
        );

        // Model: q holds the expected line level for each remaining cycle of the current frame.
        bit          q[$];
        logic [DW-1:0] mbuf;
        bit          mfull;
        bit          mdone;
        bit          m_hs;

        assign hs_v[g] = m_hs;

        always @(posedge clk or negedge rst_v[g]) begin : model
            bit start;
            if (!rst_v[g]) begin
                q.delete();
                mfull = 1'b0;
                mdone = 1'b0;
                m_hs  = 1'b0;
                mbuf  = '0;
            end else begin
                m_hs  = vld_v[g] && !mfull;
                start = 1'b0;
                if (q.size() != 0) begin
                    void'(q.pop_front());
                    mdone = (q.size() == 0);
                    start = mdone && mfull;
                end else begin
                    mdone = 1'b0;
                    start = mfull;
                end
                if (start) begin
                    for (int i = 0; i < CPB; i++) q.push_back(1'b0);
                    for (int b = 0; b < DW; b++)
                        for (int i = 0; i < CPB; i++) q.push_back(mbuf[b]);
                    if (PM != 0)
                        for (int i = 0; i < CPB; i++) q.push_back((^mbuf) ^ (PM == 2));
                    for (int i = 0; i < SB * CPB; i++) q.push_back(1'b1);
                    mfull = 1'b0;
                end
                if (m_hs) begin
                    mbuf  = dat_a[g][DW-1:0];
                    mfull = 1'b1;
                end
            end
        end

        always @(posedge clk) begin : compare
            #1;
            if (rst_v[g]) begin
                check($sformatf("u%0d_serial", g), ser_v[g], (q.size() == 0) ? 1'b1 : q[0]);
                check($sformatf("u%0d_busy", g), busy_v[g], q.size() != 0);
                check($sformatf("u%0d_ready", g), rdy_v[g], !mfull);
                check($sformatf("u%0d_done", g), done_v[g], mdone);
            end
        end
    end

    task automatic drive(input int g, input logic v, input logic [63:0] d);
        vld_v[g] = v;
        dat_a[g] = d;
    endtask

    // Offer one word into an empty buffer; returns at the negedge before the frame's first cycle.
    task automatic send(input int g, input logic [63:0] d);
        @(negedge clk);
        drive(g, 1'b1, d);
        @(negedge clk);
        drive(g, 1'b0, d);
    endtask

    // Samples each bit mid-period and records where tx_done pulses, cycle 0 = START entry.
    task automatic capture(input int g, input int cpb, input int nbits,
                           output logic [63:0] bits, output int done_at, output int pulses);
        bits    = '0;
        done_at = -1;
        pulses  = 0;
        for (int c = 0; c <= cpb * nbits; c++) begin
            @(negedge clk);
            if (c < cpb * nbits && (c % cpb) == cpb / 2) bits[c / cpb] = ser_v[g];
            if (done_v[g]) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
        end
    endtask

    // Random producer: holds each word until accepted, then drains and waits for idle.
    task automatic rand_phase(input int g, input int cycles, input int pct);
        logic        v;
        logic [63:0] d;
        int          guard;
        v = 1'b0;
        d = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!v || hs_v[g]) begin
                v = (int'($urandom_range(0, 99)) < pct);
                d = {$urandom, $urandom};
            end
            drive(g, v, d);
        end
        guard = 0;
        while (v && guard < 5000) begin
            @(negedge clk);
            if (hs_v[g]) v = 1'b0;
            drive(g, v, d);
            guard++;
        end
        guard = 0;
        while ((busy_v[g] || !rdy_v[g]) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("u%0d_drain_busy", g), busy_v[g], 1'b0);
        check($sformatf("u%0d_drain_ready", g), rdy_v[g], 1'b1);
    endtask

    initial begin : stim
        logic [63:0] bits;
        int          done_at;
        int          pulses;
        int          d1;
        int          d2;
        int          busy_low;

        rst_v = '0;
        vld_v = '0;
        for (int i = 0; i < 3; i++) dat_a[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_serial", ser_v[0], 1'b1);
        check("rst_ready", rdy_v[0], 1'b1);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        rst_v = 3'b111;
        repeat (2) @(negedge clk);

        // Even parity: 0xA5 -> start, 1,0,1,0,0,1,0,1, parity 0, stop.
        send(0, 64'hA5);
        capture(0, 4, 11, bits, done_at, pulses);
        check("a5_bits", bits[10:0], 11'b10101001010);
        check("a5_done_at", done_at, 44);
        check("a5_done_pulses", pulses, 1);

        // Reset during data bit 3 (frame cycles 16..19).
        repeat (3) @(negedge clk);
        send(0, 64'hA5);
        repeat (18) @(negedge clk);
        check("mid_pre_serial", ser_v[0], 1'b0);
        rst_v[0] = 1'b0;
        #1;
        check("mid_rst_serial", ser_v[0], 1'b1);
        check("mid_rst_busy", busy_v[0], 1'b0);
        check("mid_rst_ready", rdy_v[0], 1'b1);
        check("mid_rst_done", done_v[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check("post_rst_ready", rdy_v[0], 1'b1);
        check("post_rst_busy", busy_v[0], 1'b0);
        send(0, 64'h00);
        capture(0, 4, 11, bits, done_at, pulses);
        check("zero_bits", bits[10:0], 11'b10000000000);
        check("zero_done_at", done_at, 44);

        // Stall: 0x96 waits in the buffer while tx_data churns.
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 64'h5A);
        @(negedge clk);
        drive(0, 1'b1, 64'h96);
        bits = '0;
        d1   = -1;
        d2   = -1;
        for (int c = 0; c <= 88; c++) begin
            @(negedge clk);
            if (c == 10 || c == 30) check($sformatf("stall_ready_c%0d", c), rdy_v[0], 1'b0);
            if (c == 44) check("stall_ready_free", rdy_v[0], 1'b1);
            if (c >= 44 && c < 88 && (c % 4) == 2) bits[(c - 44) / 4] = ser_v[0];
            if (done_v[0]) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (c >= 1 && c < 44) drive(0, 1'b1, {$urandom, $urandom});
            else if (c == 44) drive(0, 1'b0, 64'h0);
        end
        check("stall_second_word", bits[10:0], {1'b1, 1'b0, 8'h96, 1'b0});
        check("stall_done1", d1, 44);
        check("stall_done2", d2, 88);

        rand_phase(0, 800, 60);

        // Odd parity, 32 ones -> parity 1; 35 bits of 16 cycles.
        send(1, 64'hFFFF_FFFF);
        capture(1, 16, 35, bits, done_at, pulses);
        check("odd_bits", bits[34:0], 35'h7_FFFF_FFFE);
        check("odd_done_at", done_at, 560);
        check("odd_done_pulses", pulses, 1);

        rand_phase(1, 1200, 50);

        // Back-to-back, no parity, two stop bits: 44-cycle frames with no gap.
        drive(2, 1'b1, 64'h3C);
        @(negedge clk);
        drive(2, 1'b1, 64'hC3);
        d1       = -1;
        d2       = -1;
        busy_low = 0;
        for (int c = 0; c <= 88; c++) begin
            @(negedge clk);
            if (c == 0) check("b2b_ready_free", rdy_v[2], 1'b1);
            if (c == 1) begin
                check("b2b_second_taken", rdy_v[2], 1'b0);
                drive(2, 1'b0, 64'hC3);
            end
            if (c == 43) check("b2b_last_stop", ser_v[2], 1'b1);
            if (c == 44) check("b2b_second_start", ser_v[2], 1'b0);
            if (c == 88) check("b2b_idle_after", busy_v[2], 1'b0);
            if (c < 88 && !busy_v[2]) busy_low++;
            if (done_v[2]) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        check("b2b_busy_gaps", busy_low, 0);
        check("b2b_done1", d1, 44);
        check("b2b_done2", d2, 88);

        rand_phase(2, 800, 90);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
